// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared image/kernel constants and sequencer state encoding
package conv_pkg;

  localparam int IMG_N = 6;
  localparam int K_N   = 3;
  localparam int OUT_N = IMG_N - K_N + 1;
  localparam int N_RES = OUT_N * OUT_N;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } conv_state_e;

endpackage

// File: rtl/rise_detect.sv
// rtl/rise_detect.sv - rising-edge detector on an already-synchronous level
module rise_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic rise
);

  logic prev_q;
  logic prev_d;

  always_comb begin
    prev_d = level;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q <= 1'b0;
    end else begin
      prev_q <= prev_d;
    end
  end

  assign rise = level & ~prev_q;

endmodule

// File: rtl/conv_sequencer.sv
// rtl/conv_sequencer.sv - row load / window scan / result count sequencer for convLayer
module conv_sequencer #(
  parameter int IMG_N = conv_pkg::IMG_N,
  parameter int K_N   = conv_pkg::K_N
) (
  input  logic                                            clk,
  input  logic                                            rst_n,
  input  logic                                            row_strobe,
  input  logic                                            start,
  output logic                                            row_we,
  output logic [$clog2(IMG_N)-1:0]                        row_addr,
  output logic                                            win_valid,
  input  logic                                            win_ready,
  output logic [$clog2(IMG_N-K_N+1)-1:0]                  win_row,
  output logic [$clog2(IMG_N-K_N+1)-1:0]                  win_col,
  input  logic                                            res_valid,
  output logic [$clog2((IMG_N-K_N+1)*(IMG_N-K_N+1))-1:0]  res_idx,
  output logic                                            busy,
  output logic                                            done,
  output logic                                            err
);

  import conv_pkg::*;

  localparam int OUT_N = IMG_N - K_N + 1;
  localparam int N_RES = OUT_N * OUT_N;
  localparam int CNT_W = $clog2(N_RES) + 1;
  localparam int RC_W  = $clog2(IMG_N + 1);
  localparam int RA_W  = $clog2(IMG_N);
  localparam int OC_W  = $clog2(OUT_N);
  localparam int RI_W  = $clog2(N_RES);

  localparam logic [RC_W-1:0]  ROWS_FULL = RC_W'(IMG_N);
  localparam logic [CNT_W-1:0] RES_FULL  = CNT_W'(N_RES);
  localparam logic [CNT_W-1:0] POS_LAST  = CNT_W'(N_RES - 1);
  localparam logic [CNT_W-1:0] OUT_N_C   = CNT_W'(OUT_N);

  logic row_rise;
  logic start_rise;

  rise_detect u_row_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (row_strobe),
    .rise  (row_rise)
  );

  rise_detect u_start_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .level (start),
    .rise  (start_rise)
  );

  conv_state_e      state_q, state_d;
  logic [RC_W-1:0]  row_cnt_q, row_cnt_d;
  logic [CNT_W-1:0] pos_q, pos_d;
  logic [CNT_W-1:0] res_cnt_q, res_cnt_d;

  logic             row_we_q, row_we_d;
  logic [RA_W-1:0]  row_addr_q, row_addr_d;
  logic             win_valid_q, win_valid_d;
  logic [OC_W-1:0]  win_row_q, win_row_d;
  logic [OC_W-1:0]  win_col_q, win_col_d;
  logic [RI_W-1:0]  res_idx_q, res_idx_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             err_d, err_q;

  logic             accept;
  logic             scanning;

  assign accept   = win_valid_q & win_ready;
  assign scanning = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);

  always_comb begin
    state_d    = state_q;
    row_cnt_d  = row_cnt_q;
    pos_d      = pos_q;
    res_cnt_d  = res_cnt_q;
    row_we_d   = 1'b0;
    row_addr_d = row_addr_q;
    err_d      = 1'b0;

    // Results are counted first so the ISSUE/DRAIN exits see this cycle's result.
    if (res_valid) begin
      if (scanning && (res_cnt_q != RES_FULL)) begin
        res_cnt_d = res_cnt_q + CNT_W'(1);
      end else begin
        err_d = 1'b1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (row_rise && (row_cnt_q < ROWS_FULL)) begin
          row_we_d   = 1'b1;
          row_addr_d = RA_W'(row_cnt_q);
          row_cnt_d  = row_cnt_q + RC_W'(1);
        end
        // A start that loses the race with the final row is rejected, not deferred.
        if (start_rise) begin
          if (row_cnt_q == ROWS_FULL) begin
            state_d   = ST_ISSUE;
            pos_d     = '0;
            res_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      ST_ISSUE: begin
        if (accept) begin
          pos_d = pos_q + CNT_W'(1);
          if (pos_q == POS_LAST) begin
            state_d = (res_cnt_d == RES_FULL) ? ST_DONE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (res_cnt_d == RES_FULL) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (row_rise) begin
          row_we_d   = 1'b1;
          row_addr_d = '0;
          row_cnt_d  = RC_W'(1);
          state_d    = ST_IDLE;
        end else if (start_rise) begin
          state_d   = ST_ISSUE;
          pos_d     = '0;
          res_cnt_d = '0;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    win_valid_d = (state_d == ST_ISSUE);
    win_row_d   = win_row_q;
    win_col_d   = win_col_q;
    if (state_d == ST_ISSUE) begin
      win_row_d = OC_W'(pos_d / OUT_N_C);
      win_col_d = OC_W'(pos_d % OUT_N_C);
    end
    res_idx_d = RI_W'(res_cnt_d);
    busy_d    = (state_d == ST_ISSUE) || (state_d == ST_DRAIN);
    done_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_cnt_q   <= '0;
      pos_q       <= '0;
      res_cnt_q   <= '0;
      row_we_q    <= 1'b0;
      row_addr_q  <= '0;
      win_valid_q <= 1'b0;
      win_row_q   <= '0;
      win_col_q   <= '0;
      res_idx_q   <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_cnt_q   <= row_cnt_d;
      pos_q       <= pos_d;
      res_cnt_q   <= res_cnt_d;
      row_we_q    <= row_we_d;
      row_addr_q  <= row_addr_d;
      win_valid_q <= win_valid_d;
      win_row_q   <= win_row_d;
      win_col_q   <= win_col_d;
      res_idx_q   <= res_idx_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign row_we    = row_we_q;
  assign row_addr  = row_addr_q;
  assign win_valid = win_valid_q;
  assign win_row   = win_row_q;
  assign win_col   = win_col_q;
  assign res_idx   = res_idx_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_conv_sequencer.sv
// tb/tb_conv_sequencer.sv - table, directed and random checks of conv_sequencer
module tb_conv_sequencer;

  localparam int IMG  = 6;
  localparam int OUTN = 4;
  localparam int NRES = 16;
  localparam int P_IDLE = 0, P_ISSUE = 1, P_DRAIN = 2, P_DONE = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       row_strobe = 1'b0;
  logic       start = 1'b0;
  logic       win_ready = 1'b0;
  logic       res_valid = 1'b0;
  logic       row_we;
  logic [2:0] row_addr;
  logic       win_valid;
  logic [1:0] win_row;
  logic [1:0] win_col;
  logic [3:0] res_idx;
  logic       busy;
  logic       done;
  logic       err;

  conv_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .row_strobe (row_strobe),
    .start      (start),
    .row_we     (row_we),
    .row_addr   (row_addr),
    .win_valid  (win_valid),
    .win_ready  (win_ready),
    .win_row    (win_row),
    .win_col    (win_col),
    .res_valid  (res_valid),
    .res_idx    (res_idx),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  // Reference model: rows loaded, phase, and the queue of window positions still to issue.
  int m_rows, m_phase, m_res, m_rs_prev, m_st_prev;
  int q_r[$];
  int q_c[$];
  int e_we, e_addr, e_err, e_valid, e_row, e_col, e_idx, e_busy, e_done;

  typedef struct {
    bit rs; bit st; bit rv;
    bit we; int addr; bit err; bit busy;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  function automatic void model_reset();
    m_rows = 0; m_phase = P_IDLE; m_res = 0; m_rs_prev = 0; m_st_prev = 0;
    q_r.delete(); q_c.delete();
    e_we = 0; e_addr = 0; e_err = 0; e_valid = 0; e_row = 0; e_col = 0;
    e_idx = 0; e_busy = 0; e_done = 0;
  endfunction

  function automatic void start_scan();
    m_phase = P_ISSUE;
    m_res = 0;
    q_r.delete(); q_c.delete();
    for (int r = 0; r < OUTN; r++)
      for (int c = 0; c < OUTN; c++) begin
        q_r.push_back(r);
        q_c.push_back(c);
      end
  endfunction

  function automatic void model_step(input bit rs, input bit st, input bit wr, input bit rv);
    bit rse = rs && !m_rs_prev;
    bit ste = st && !m_st_prev;
    int ph = m_phase;
    int rows_before = m_rows;
    m_rs_prev = rs;
    m_st_prev = st;
    e_we = 0;
    e_err = 0;
    if (rv) begin
      if ((ph == P_ISSUE || ph == P_DRAIN) && m_res < NRES) m_res++;
      else e_err = 1;
    end
    case (ph)
      P_IDLE: begin
        if (rse && rows_before < IMG) begin
          e_we = 1; e_addr = rows_before; m_rows = rows_before + 1;
        end
        if (ste) begin
          if (rows_before == IMG) start_scan();
          else e_err = 1;
        end
      end
      P_ISSUE: if (wr) begin
        void'(q_r.pop_front());
        void'(q_c.pop_front());
        if (q_r.size() == 0) m_phase = (m_res == NRES) ? P_DONE : P_DRAIN;
      end
      P_DRAIN: if (m_res == NRES) m_phase = P_DONE;
      default: begin
        if (rse) begin
          e_we = 1; e_addr = 0; m_rows = 1; m_phase = P_IDLE;
        end else if (ste) start_scan();
      end
    endcase
    e_valid = (m_phase == P_ISSUE);
    if (e_valid) begin
      e_row = q_r[0];
      e_col = q_c[0];
    end
    e_idx  = m_res % NRES;
    e_busy = (m_phase == P_ISSUE || m_phase == P_DRAIN);
    e_done = (m_phase == P_DONE);
  endfunction

  task automatic drive(input bit rs, input bit st, input bit wr, input bit rv);
    @(negedge clk);
    row_strobe = rs; start = st; win_ready = wr; res_valid = rv;
    model_step(rs, st, wr, rv);
    @(posedge clk);
    #1;
  endtask

  task automatic cyc(input bit rs, input bit st, input bit wr, input bit rv);
    drive(rs, st, wr, rv);
    chk("row_we", int'(row_we), e_we);
    chk("row_addr", int'(row_addr), e_addr);
    chk("err", int'(err), e_err);
    chk("win_valid", int'(win_valid), e_valid);
    chk("win_row", int'(win_row), e_row);
    chk("win_col", int'(win_col), e_col);
    chk("res_idx", int'(res_idx), e_idx);
    chk("busy", int'(busy), e_busy);
    chk("done", int'(done), e_done);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_row_we"}, int'(row_we), 0);
    chk({tag, "_row_addr"}, int'(row_addr), 0);
    chk({tag, "_win_valid"}, int'(win_valid), 0);
    chk({tag, "_win_pos"}, int'({win_row, win_col}), 0);
    chk({tag, "_res_idx"}, int'(res_idx), 0);
    chk({tag, "_busy_done_err"}, int'({busy, done, err}), 0);
  endtask

  task automatic apply_reset(input string tag);
    @(negedge clk);
    rst_n = 1'b0;
    row_strobe = 0; start = 0; win_ready = 0; res_valid = 0;
    #1;
    check_reset_outputs(tag);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic load_rows(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1, 0, 0, 0);
      cyc(0, 0, 0, 0);
    end
  endtask

  initial begin
    int n;
    bit rs, st, wr, rv;
    int outstanding;

    tbl[0]  = '{1, 0, 0, 1, 0, 0, 0};
    tbl[1]  = '{0, 0, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 0, 1, 1, 0, 0};
    tbl[3]  = '{0, 0, 0, 0, 1, 0, 0};
    tbl[4]  = '{1, 0, 0, 1, 2, 0, 0};
    tbl[5]  = '{0, 1, 0, 0, 2, 1, 0};
    tbl[6]  = '{0, 0, 0, 0, 2, 0, 0};
    tbl[7]  = '{1, 1, 0, 1, 3, 1, 0};
    tbl[8]  = '{0, 0, 0, 0, 3, 0, 0};
    tbl[9]  = '{1, 0, 0, 1, 4, 0, 0};
    tbl[10] = '{0, 0, 1, 0, 4, 1, 0};
    tbl[11] = '{1, 0, 0, 1, 5, 0, 0};
    tbl[12] = '{0, 0, 0, 0, 5, 0, 0};
    tbl[13] = '{1, 0, 0, 0, 5, 0, 0};
    tbl[14] = '{0, 0, 0, 0, 5, 0, 0};

    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_reset_outputs("por");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 15; i++) begin
      drive(tbl[i].rs, tbl[i].st, 1'b0, tbl[i].rv);
      chk($sformatf("tbl%0d_we", i), int'(row_we), int'(tbl[i].we));
      chk($sformatf("tbl%0d_addr", i), int'(row_addr), tbl[i].addr);
      chk($sformatf("tbl%0d_err", i), int'(err), int'(tbl[i].err));
      chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].busy));
      chk($sformatf("tbl%0d_idx", i), int'(res_idx), 0);
    end

    cyc(0, 1, 1, 0);
    for (int k = 0; k < NRES; k++) begin
      chk("scan_valid", int'(win_valid), 1);
      chk("scan_pos", int'(win_row) * OUTN + int'(win_col), k);
      cyc(0, 0, 1, 0);
    end
    chk("scan_end_valid", int'(win_valid), 0);
    chk("scan_end_busy", int'(busy), 1);
    for (int k = 0; k < NRES; k++) begin
      chk("drain_idx", int'(res_idx), k);
      chk("drain_not_done", int'(done), 0);
      cyc(0, 0, 0, 1);
    end
    chk("done_after_last", int'(done), 1);
    chk("busy_after_last", int'(busy), 0);
    cyc(0, 0, 0, 1);
    chk("extra_res_err", int'(err), 1);
    chk("extra_res_done", int'(done), 1);
    cyc(0, 0, 0, 0);

    cyc(0, 1, 0, 0);
    chk("rescan_valid", int'(win_valid), 1);
    n = 0;
    while (win_valid && n < 100) begin
      cyc(0, 0, n[0], 0);
      n++;
    end
    chk("bp_issue_cycles", n, 32);
    for (int k = 0; k < NRES; k++) cyc(0, 0, 0, 1);
    chk("rescan_done", int'(done), 1);
    cyc(0, 0, 0, 0);
    cyc(1, 0, 0, 0);
    chk("reload_we", int'(row_we), 1);
    chk("reload_addr", int'(row_addr), 0);
    chk("reload_done", int'(done), 0);
    cyc(0, 0, 0, 0);

    load_rows(5);
    cyc(0, 1, 1, 0);
    for (int k = 0; k < 7; k++) cyc(0, 0, 1, 0);
    chk("mid_pos", int'(win_row) * OUTN + int'(win_col), 7);
    apply_reset("midrst");
    cyc(0, 1, 0, 0);
    chk("start_unloaded_err", int'(err), 1);
    chk("start_unloaded_valid", int'(win_valid), 0);
    cyc(0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      rs = ($urandom_range(0, 3) == 0);
      st = ($urandom_range(0, 5) == 0);
      wr = ($urandom_range(0, 2) != 0);
      outstanding = (m_phase == P_ISSUE) ? (NRES - q_r.size() - m_res) :
                    (m_phase == P_DRAIN) ? (NRES - m_res) : 0;
      rv = (outstanding > 0) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 15) == 0);
      cyc(rs, st, wr, rv);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
